result_display_encoder: RTL and testbench

- Read-side counterpart to the four-function calculator: consumes the calculator's two's-complement Result and Overflow and drives the board's seven-segment displays.
- Converts the signed value to sign plus magnitude, then to BCD with a sequential double-dabble engine (one bit per clock).
- Raises CantDisplay when the value cannot be shown.
- Sits between the calculator core and the HEX outputs.

---
 rtl/result_display_encoder.sv | 163 ++++++++++++++++
 tb/tb_result_display_encoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/result_display_encoder.sv
// ============================================================================
//  Module   : result_display_encoder
//  Purpose  : Signed calculator result -> sign/magnitude -> BCD (sequential
//             double-dabble, one bit per clock) -> active-low 7-segment fields.
//             Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module result_display_encoder #(
    parameter int W      = 11,
    parameter int DIGITS = 4
) (
    input  logic                      Clock,
    input  logic                      Clear,
    input  logic                      Start,
    input  logic [W-1:0]              Result,
    input  logic                      Overflow,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Negative,
    output logic                      CantDisplay,
    output logic [4*DIGITS-1:0]       BCD,
    output logic [7*(DIGITS+1)-1:0]   Seg
);

    // Internal digit count: ceil(W*log10(2)) plus one spare digit.
    localparam int ND = (W * 302 + 999) / 1000 + 1;
    localparam int CW = $clog2(W + 1);
    localparam logic [6:0] C_BLANK = 7'b1111111;
    localparam logic [6:0] C_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    logic [CW-1:0]            r_cnt;
    logic [W-1:0]             r_mag;
    logic [4*ND-1:0]          r_bcd;
    logic                     r_ovf;
    logic                     r_sign;

    logic [4*ND-1:0]          w_adj;
    logic [4*(ND+DIGITS)-1:0] w_ext;
    logic [4*DIGITS-1:0]      w_digits;
    logic                     w_cant;
    logic                     w_neg;
    logic [7*(DIGITS+1)-1:0]  w_seg;
`ifdef LEADING_ZERO_BLANK_EN
    logic                     w_seen;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = C_BLANK;
        endcase
    endfunction

    always_comb begin
        w_adj = '0;
        for (int i = 0; i < ND; i++) begin
            w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                        : r_bcd[4*i +: 4];
        end
    end

    // Zero-extend so the displayable/overflow split works for any DIGITS vs ND.
    assign w_ext    = {{(4*DIGITS){1'b0}}, r_bcd};
    assign w_digits = w_ext[4*DIGITS-1:0];
    assign w_cant   = r_ovf | (|(w_ext >> (4*DIGITS)));
    assign w_neg    = r_sign & (|r_bcd) & ~w_cant;

    always_comb begin
        w_seg = '1;
`ifdef LEADING_ZERO_BLANK_EN
        w_seen = 1'b0;
`endif
        if (w_cant) begin
            for (int i = 0; i <= DIGITS; i++) w_seg[7*i +: 7] = C_DASH;
        end else begin
            for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
                if (w_digits[4*i +: 4] != 4'd0) w_seen = 1'b1;
                w_seg[7*i +: 7] = (w_seen || i == 0) ? seg7(w_digits[4*i +: 4]) : C_BLANK;
`else
                w_seg[7*i +: 7] = seg7(w_digits[4*i +: 4]);
`endif
            end
            w_seg[7*DIGITS +: 7] = w_neg ? C_DASH : C_BLANK;
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mag       <= '0;
            r_bcd       <= '0;
            r_ovf       <= 1'b0;
            r_sign      <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Negative    <= 1'b0;
            CantDisplay <= 1'b0;
            BCD         <= '0;
            Seg         <= '1;
        end else begin
            Done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        // Unsigned negate keeps -2^(W-1) as 2^(W-1).
                        r_mag   <= Result[W-1] ? -Result : Result;
                        r_sign  <= Result[W-1];
                        r_ovf   <= Overflow;
                        r_bcd   <= '0;
                        r_cnt   <= CW'(W);
                        Busy    <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (r_cnt == '0) begin
                        Done        <= 1'b1;
                        CantDisplay <= w_cant;
                        Negative    <= w_neg;
                        BCD         <= w_cant ? '0 : w_digits;
                        Seg         <= w_seg;
                        r_state     <= S_DONE;
                    end else begin
                        r_bcd <= {w_adj[4*ND-2:0], r_mag[W-1]};
                        r_mag <= r_mag << 1;
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    Busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    Busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_result_display_encoder.sv
// ============================================================================
//  Module   : tb_result_display_encoder
//  Purpose  : Directed plus random checks of result_display_encoder against an
//             arithmetic reference model (DIGITS=4 and DIGITS=3 instances).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_result_display_encoder;

    localparam int W = 11;

    logic        clk = 1'b0;
    logic        clear, start, ovf;
    logic [W-1:0] res;

    logic        busy, done, neg, cant;
    logic [15:0] bcd;
    logic [34:0] seg;
    logic        busy3, done3, neg3, cant3;
    logic [11:0] bcd3;
    logic [27:0] seg3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    result_display_encoder #(.W(W), .DIGITS(4)) dut (
        .Clock(clk), .Clear(clear), .Start(start), .Result(res), .Overflow(ovf),
        .Busy(busy), .Done(done), .Negative(neg), .CantDisplay(cant),
        .BCD(bcd), .Seg(seg)
    );

    result_display_encoder #(.W(W), .DIGITS(3)) dut3 (
        .Clock(clk), .Clear(clear), .Start(start), .Result(res), .Overflow(ovf),
        .Busy(busy3), .Done(done3), .Negative(neg3), .CantDisplay(cant3),
        .BCD(bcd3), .Seg(seg3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] segcode(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  default: return 7'b0010000;
        endcase
    endfunction

    // Decimal reference: value from the signed integer, digits by /10 and %10.
    task automatic model(input logic [W-1:0] r, input logic o, input int nd,
                         output logic [15:0] eb, output logic en, output logic ec,
                         output logic [34:0] es);
        int v, mag, tmp, msd;
        int dig[4];
        v   = $signed(r);
        mag = (v < 0) ? -v : v;
        ec  = o || (mag >= 10**nd);
        eb  = '0;
        en  = 1'b0;
        es  = {5{7'b0111111}};
        if (!ec) begin
            tmp = mag;
            msd = 0;
            for (int i = 0; i < 4; i++) begin
                dig[i] = (i < nd) ? tmp % 10 : 0;
                if (i < nd) tmp = tmp / 10;
                eb[4*i +: 4] = 4'(dig[i]);
                if (dig[i] != 0) msd = i;
            end
            en = (v < 0);
            for (int i = 0; i < 4; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
                es[7*i +: 7] = (i > msd) ? 7'b1111111 : segcode(dig[i]);
`else
                es[7*i +: 7] = segcode(dig[i]);
`endif
            end
            es[28 +: 7] = en ? 7'b0111111 : 7'b1111111;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_neg"},  64'(neg),  64'd0);
        check({tag, "_cant"}, 64'(cant), 64'd0);
        check({tag, "_bcd"},  64'(bcd),  64'd0);
        check({tag, "_seg"},  64'(seg),  64'h7_FFFF_FFFF);
    endtask

    // Start at edge N; optional second Start / Clear at edge N+k.
    task automatic conv(input string tag, input logic [W-1:0] r, input logic o,
                        input int restart_at, input int clear_at);
        logic [15:0] eb, eb3;
        logic        en, ec, en3, ec3;
        logic [34:0] es, es3;
        int          k;
        bit          got;
        model(r, o, 4, eb, en, ec, es);
        model(r, o, 3, eb3, en3, ec3, es3);
        res = r; ovf = o; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        res = W'($urandom); ovf = 1'($urandom);
        got = 0;
        k   = 0;
        while (!got && k < 30) begin
            k++;
            start = (k == restart_at);
            clear = (k == clear_at);
            @(posedge clk); #1;
            start = 1'b0; clear = 1'b0;
            if (k == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
            if (done) got = 1;
        end
        if (clear_at > 0) begin
            check({tag, "_nodone"}, 64'(got), 64'd0);
            check_reset({tag, "_clr"});
        end else begin
            check({tag, "_latency"}, 64'(got ? k : -1), 64'd12);
            check({tag, "_bcd"},  64'(bcd),  64'(eb));
            check({tag, "_neg"},  64'(neg),  64'(en));
            check({tag, "_cant"}, 64'(cant), 64'(ec));
            check({tag, "_seg"},  64'(seg),  64'(es));
            check({tag, "_d3_cant"}, 64'(cant3), 64'(ec3));
            check({tag, "_d3_bcd"},  64'(bcd3),  64'(eb3[11:0]));
            @(posedge clk); #1;
            check({tag, "_pulse"}, 64'(done), 64'd0);
            check({tag, "_idle"},  64'(busy), 64'd0);
        end
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; res = '0; ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        clear = 1'b0;

        conv("pos3",    11'd3,    1'b0, 0, 0);
        conv("neg1",    11'h7FF,  1'b0, 0, 0);
        conv("min",     11'h400,  1'b0, 0, 0);
        conv("zero",    11'd0,    1'b0, 0, 0);
        conv("ovf",     11'h409,  1'b1, 0, 0);
        conv("max",     11'd1023, 1'b0, 0, 0);
        conv("d42",     11'd42,   1'b0, 0, 0);
        conv("nd7",     11'h7F9,  1'b0, 0, 0);
        conv("restart", 11'd517,  1'b0, 4, 0);
        conv("clrmid",  11'd999,  1'b0, 0, 6);
        conv("after",   11'd808,  1'b0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            conv("rand", W'($urandom), ($urandom_range(0, 7) == 0), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
